keypad_entry: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it and decodes one key per press.

---
 rtl/keypad_entry.sv | 272 +++++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner, debouncer and BCD entry buffer.
// Drives one column low at a time. Samples the synchronised rows once per column
// period and classifies each full scan as NONE, ONE(key) or MULTI. A debounce FSM
// accepts one key per press. Accepted keys edit a 4-digit BCD entry buffer that is
// latched to 'code' on ENTER.
// Optional build macro: KEYPAD_REPEAT_EN enables auto-repeat of a held key.
// Handshake: key_valid and code_valid are single-cycle strobes with no back-pressure.
// key_code and code stay stable until the next strobe.
module keypad_entry #(
    parameter int SCAN_COUNT     = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] entry,
    output logic [2:0]  entry_cnt,
    output logic [15:0] code,
    output logic        code_valid
);

    localparam int SC_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_COUNT - 1);
    localparam logic [DB_W-1:0] DB_TGT  = DB_W'(DEBOUNCE_SCANS);
    localparam logic [RP_W-1:0] RP_TGT  = RP_W'(REPEAT_SCANS);

`ifdef KEYPAD_REPEAT_EN
    localparam logic REPEAT_ON = 1'b1;
`else
    localparam logic REPEAT_ON = 1'b0;
`endif

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]      row_s1_q, row_s2_q;
    logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      col_q, col_d;
    logic [1:0]      hit_cnt_q, hit_cnt_d;
    logic [3:0]      hit_key_q, hit_key_d;
    logic [1:0]      state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic [15:0]     entry_q, entry_d;
    logic [2:0]      entry_cnt_q, entry_cnt_d;
    logic [15:0]     code_q, code_d;
    logic            code_valid_q, code_valid_d;

    logic [3:0] row_low;
    logic [2:0] col_hits;
    logic [1:0] row_idx;
    logic [2:0] tot;
    logic [1:0] tot_sat;
    logic [3:0] acc_key;
    logic       sample, scan_end, res_one;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Classify the current column sample and fold it into the running scan result
    always_comb begin
        row_low  = ~row_s2_q;
        col_hits = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
        row_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) row_idx = 2'(i);
        end
        tot      = {1'b0, hit_cnt_q} + col_hits;
        tot_sat  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        acc_key  = (col_hits == 3'd1) ? key_map(row_idx, col_idx_q) : hit_key_q;
        sample   = en && (scan_cnt_q == SC_LAST);
        scan_end = sample && (col_idx_q == 2'd3);
        res_one  = (tot_sat == 2'd1);
    end

    // Column stepping and per-scan hit accumulation; everything freezes while en=0
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        col_idx_d  = col_idx_q;
        hit_cnt_d  = hit_cnt_q;
        hit_key_d  = hit_key_q;
        col_d      = 4'hF;
        if (en) begin
            if (sample) begin
                scan_cnt_d = '0;
                col_idx_d  = col_idx_q + 2'd1;
                if (scan_end) begin
                    hit_cnt_d = 2'd0;
                    hit_key_d = 4'h0;
                end else begin
                    hit_cnt_d = tot_sat;
                    hit_key_d = acc_key;
                end
            end else begin
                scan_cnt_d = scan_cnt_q + SC_W'(1);
            end
            col_d = ~(4'b0001 << col_idx_d);
        end
    end

    // Debounce FSM, stepped once per completed scan; MULTI counts as NONE except in RELEASE
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (!en) begin
            state_d   = S_IDLE;
            db_cnt_d  = '0;
            rep_cnt_d = '0;
        end else if (scan_end) begin
            case (state_q)
                S_IDLE: begin
                    if (res_one) begin
                        cand_d   = acc_key;
                        db_cnt_d = DB_W'(1);
                        state_d  = S_DEBOUNCE;
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d     = S_PRESSED;
                            key_code_d  = acc_key;
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (res_one && (acc_key == cand_q)) begin
                        if (db_cnt_q + DB_W'(1) == DB_TGT) begin
                            state_d     = S_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                        end else begin
                            db_cnt_d = db_cnt_q + DB_W'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (!res_one) begin
                        db_cnt_d = DB_W'(1);
                        state_d  = (DEBOUNCE_SCANS <= 1) ? S_IDLE : S_RELEASE;
                    end else if (REPEAT_ON) begin
                        if (rep_cnt_q + RP_W'(1) == RP_TGT) begin
                            rep_cnt_d = '0;
                            if (cand_q != 4'hC) begin
                                key_code_d  = cand_q;
                                key_valid_d = 1'b1;
                            end
                        end else begin
                            rep_cnt_d = rep_cnt_q + RP_W'(1);
                        end
                    end
                end
                default: begin
                    if (tot_sat == 2'd0) begin
                        if (db_cnt_q + DB_W'(1) == DB_TGT) state_d = S_IDLE;
                        else db_cnt_d = db_cnt_q + DB_W'(1);
                    end else begin
                        state_d = S_PRESSED;
                    end
                end
            endcase
        end
    end

    // Entry buffer editing, one clock after each accepted key strobe
    always_comb begin
        entry_d      = entry_q;
        entry_cnt_d  = entry_cnt_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        if (en && key_valid_q) begin
            if (key_code_q <= 4'd9) begin
                if (entry_cnt_q < 3'd4) begin
                    entry_d     = {entry_q[11:0], key_code_q};
                    entry_cnt_d = entry_cnt_q + 3'd1;
                end
            end else if (key_code_q == 4'hA) begin
                if (entry_cnt_q != 3'd0) begin
                    entry_d     = entry_q >> 4;
                    entry_cnt_d = entry_cnt_q - 3'd1;
                end
            end else if (key_code_q == 4'hB) begin
                entry_d     = 16'h0;
                entry_cnt_d = 3'd0;
            end else if (key_code_q == 4'hC) begin
                code_d       = entry_q;
                code_valid_d = 1'b1;
                entry_d      = 16'h0;
                entry_cnt_d  = 3'd0;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q     <= 4'hF;
            row_s2_q     <= 4'hF;
            scan_cnt_q   <= '0;
            col_idx_q    <= 2'd0;
            col_q        <= 4'hF;
            hit_cnt_q    <= 2'd0;
            hit_key_q    <= 4'h0;
            state_q      <= S_IDLE;
            cand_q       <= 4'h0;
            db_cnt_q     <= '0;
            rep_cnt_q    <= '0;
            key_code_q   <= 4'h0;
            key_valid_q  <= 1'b0;
            entry_q      <= 16'h0;
            entry_cnt_q  <= 3'd0;
            code_q       <= 16'h0;
            code_valid_q <= 1'b0;
        end else begin
            row_s1_q     <= row;
            row_s2_q     <= row_s1_q;
            scan_cnt_q   <= scan_cnt_d;
            col_idx_q    <= col_idx_d;
            col_q        <= col_d;
            hit_cnt_q    <= hit_cnt_d;
            hit_key_q    <= hit_key_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            db_cnt_q     <= db_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            entry_q      <= entry_d;
            entry_cnt_q  <= entry_cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign col        = col_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_held   = (state_q == S_PRESSED) || (state_q == S_RELEASE);
    assign entry      = entry_q;
    assign entry_cnt  = entry_cnt_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with SCAN_COUNT=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3.
// A behavioural keypad pulls a row low when its column is driven low and the key is down.
// One scan is 16 clocks.
module tb_keypad_entry;

    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid, key_held;
    logic [15:0] entry;
    logic [2:0]  entry_cnt;
    logic [15:0] code;
    logic        code_valid;

    logic [15:0] keys = 16'h0;   // bit r*4+c set = key at row r, column c is down
    int          n_checks = 0;
    int          n_pass   = 0;
    int          kv_cnt   = 0;
    int          cv_cnt   = 0;
    logic [3:0]  last_key = 4'h0;
    logic [15:0] last_code = 16'h0;
    int          base;

    keypad_entry #(.SCAN_COUNT(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut (
        .clk(clk), .rst(rst), .en(en), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .entry(entry), .entry_cnt(entry_cnt), .code(code), .code_valid(code_valid)
    );

    // Clock
    always #5 clk = ~clk;

    // Keypad matrix model
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt   = kv_cnt + 1;
            last_key = key_code;
        end
        if (code_valid) begin
            cv_cnt    = cv_cnt + 1;
            last_code = code;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_keys(input logic [15:0] m, input int scans);
        keys = m;
        tick(scans * SCAN);
    endtask

    task automatic release_keys();
        keys = 16'h0;
        tick(4 * SCAN);
    endtask

    task automatic tap(input int r, input int c);
        hold_keys(16'h1 << (r*4 + c), 3);
        release_keys();
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_col", 16'(col), 16'hF);
        check("rst_key_code", 16'(key_code), 16'h0);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_key_held", 16'(key_held), 16'h0);
        check("rst_entry", entry, 16'h0);
        check("rst_entry_cnt", 16'(entry_cnt), 16'h0);
        check("rst_code", code, 16'h0);
        check("rst_code_valid", 16'(code_valid), 16'h0);

        // Column stepping
        rst = 1'b0;
        tick(1);
        check("col_step0", 16'(col), 16'hE);
        tick(3);
        check("col_step1", 16'(col), 16'hD);
        tick(4);
        check("col_step2", 16'(col), 16'hB);
        tick(4);
        check("col_step3", 16'(col), 16'h7);
        tick(4);
        check("col_wrap", 16'(col), 16'hE);

        // Single press of '5'
        base = kv_cnt;
        hold_keys(16'h1 << 5, 3);
        check("held_5", 16'(key_held), 16'h1);
        release_keys();
        check("press5_pulses", 16'(kv_cnt - base), 16'h1);
        check("press5_code", 16'(last_key), 16'h5);
        check("press5_entry", entry, 16'h0005);
        check("press5_cnt", 16'(entry_cnt), 16'h1);
        check("press5_released", 16'(key_held), 16'h0);

        // Clear, fill past four digits, backspace, enter
        tap(1, 3);
        check("clear_entry", entry, 16'h0);
        check("clear_cnt", 16'(entry_cnt), 16'h0);
        tap(0, 0); tap(0, 1); tap(0, 2); tap(1, 0); tap(1, 1);
        check("full_entry", entry, 16'h1234);
        check("full_cnt", 16'(entry_cnt), 16'h4);
        tap(0, 3);
        check("bksp_entry", entry, 16'h0123);
        check("bksp_cnt", 16'(entry_cnt), 16'h3);
        base = cv_cnt;
        tap(2, 3);
        check("enter_pulses", 16'(cv_cnt - base), 16'h1);
        check("enter_code", last_code, 16'h0123);
        check("enter_code_out", code, 16'h0123);
        check("enter_entry", entry, 16'h0);
        check("enter_cnt", 16'(entry_cnt), 16'h0);

        // Backspace on empty buffer, and a non-editing key
        tap(0, 3);
        check("bksp_empty_cnt", 16'(entry_cnt), 16'h0);
        tap(3, 3);
        check("key_d_code", 16'(last_key), 16'hD);
        check("key_d_entry", entry, 16'h0);

        // One-scan glitch and two keys in one column are both rejected
        base = kv_cnt;
        hold_keys(16'h1 << 0, 1);
        release_keys();
        check("glitch_pulses", 16'(kv_cnt - base), 16'h0);
        hold_keys((16'h1 << 0) | (16'h1 << 4), 3);
        release_keys();
        check("multi_pulses", 16'(kv_cnt - base), 16'h0);
        check("multi_entry", entry, 16'h0);

        // Long hold of '7'
        base = kv_cnt;
        hold_keys(16'h1 << 8, 10);
        release_keys();
`ifdef KEYPAD_REPEAT_EN
        check("hold7_pulses", 16'(kv_cnt - base), 16'h3);
        check("hold7_entry", entry, 16'h0777);
        check("hold7_cnt", 16'(entry_cnt), 16'h3);
`else
        check("hold7_pulses", 16'(kv_cnt - base), 16'h1);
        check("hold7_entry", entry, 16'h0007);
        check("hold7_cnt", 16'(entry_cnt), 16'h1);
`endif
        check("hold7_code", 16'(last_key), 16'h7);

        // Disable while '8' is held
        tap(1, 3);
        hold_keys(16'h1 << 9, 3);
        check("en_pre_entry", entry, 16'h0008);
        base = kv_cnt;
        en = 1'b0;
        tick(2);
        check("en_off_col", 16'(col), 16'hF);
        check("en_off_held", 16'(key_held), 16'h0);
        tick(3 * SCAN);
        check("en_off_pulses", 16'(kv_cnt - base), 16'h0);
        check("en_off_entry", entry, 16'h0008);
        keys = 16'h0;
        en = 1'b1;
        tick(4 * SCAN);
        check("en_on_pulses", 16'(kv_cnt - base), 16'h0);
        check("en_on_entry", entry, 16'h0008);

        // Reset while '9' is held: must debounce again afterwards
        hold_keys(16'h1 << 10, 3);
        rst = 1'b1;
        tick(2);
        check("midrst_entry", entry, 16'h0);
        check("midrst_held", 16'(key_held), 16'h0);
        check("midrst_key_code", 16'(key_code), 16'h0);
        rst = 1'b0;
        base = kv_cnt;
        tick(SCAN);
        check("midrst_one_scan", 16'(kv_cnt - base), 16'h0);
        tick(2 * SCAN);
        check("midrst_reaccept", 16'(kv_cnt - base), 16'h1);
        check("midrst_entry9", entry, 16'h0009);
        release_keys();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
